// File: rtl/instruction_fetch.sv
// instruction_fetch: PC generation and IF/ID pipeline register for a single-issue core.
// Holds the PC and issues it as a combinational instruction-memory address. Each
// cycle it either loads the fetched word into IF/ID, holds, or inserts a bubble.
// A two-state RUN/HALT FSM stops fetching on a decoder halt request or a
// misaligned branch redirect. Only rst leaves HALT.
// Optional feature: define IF_PERF_CNT_EN to add the fetch_count and bubble_count
// performance counters.
module instruction_fetch #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  input  logic        halt_req,
  output logic [63:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        halted,
  output logic        fault
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
`endif
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  // Sequential next PC. Addition wraps modulo 2^64 with no carry out.
  function automatic logic [63:0] pc_inc(input logic [63:0] pc);
    return pc + 64'd4;
  endfunction

  // Instructions are word aligned, so a redirect with nonzero low bits is illegal.
  function automatic logic is_misaligned(input logic [63:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

  state_t      state_p0;
  state_t      state_nxt;
  logic [63:0] pc_p0;
  logic [63:0] pc_nxt;
  logic        fault_p0;
  logic        set_fault;
  logic        load_instr;
  logic        load_bubble;

  logic [63:0] if_id_pc_p1;
  logic [31:0] if_id_instr_p1;
  logic        vld_p1;

  // Next-state, next-PC and IF/ID load decode. Priority is branch, then halt_req, then stall.
  always_comb begin
    state_nxt   = state_p0;
    pc_nxt      = pc_p0;
    set_fault   = 1'b0;
    load_instr  = 1'b0;
    load_bubble = 1'b0;
    case (state_p0)
      RUN: begin
        if (branch_taken) begin
          load_bubble = 1'b1;
          if (is_misaligned(branch_target)) begin
            set_fault = 1'b1;
            state_nxt = HALT;
          end else begin
            pc_nxt = branch_target;
          end
        end else if (halt_req) begin
          load_bubble = 1'b1;
          state_nxt   = HALT;
        end else if (!stall) begin
          load_instr = 1'b1;
          pc_nxt     = pc_inc(pc_p0);
        end
      end
      HALT: begin
        // All inputs are ignored until reset.
        state_nxt = HALT;
      end
      default: begin
        state_nxt = HALT;
      end
    endcase
  end

  // ---- stage p0: FSM state, sticky fault and PC register ----
  // Control state update; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= RUN;
      fault_p0 <= 1'b0;
      pc_p0    <= RESET_PC;
    end else begin
      state_p0 <= state_nxt;
      fault_p0 <= fault_p0 | set_fault;
      pc_p0    <= pc_nxt;
    end
  end

  // ---- stage p1: IF/ID pipeline register ----
  // Load a fetched word or a bubble. Otherwise hold, which covers stall and HALT.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_pc_p1    <= 64'h0;
      if_id_instr_p1 <= NOP_INSTR;
      vld_p1         <= 1'b0;
    end else if (load_instr) begin
      if_id_pc_p1    <= pc_p0;
      if_id_instr_p1 <= imem_rdata;
      vld_p1         <= 1'b1;
    end else if (load_bubble) begin
      if_id_pc_p1    <= pc_p0;
      if_id_instr_p1 <= NOP_INSTR;
      vld_p1         <= 1'b0;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_p1;
  logic [31:0] bubble_cnt_p1;

  // Count IF/ID loads by kind. Counters wrap modulo 2^32, and hold edges count neither.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_p1  <= 32'h0;
      bubble_cnt_p1 <= 32'h0;
    end else begin
      if (load_instr)  fetch_cnt_p1  <= fetch_cnt_p1 + 32'd1;
      if (load_bubble) bubble_cnt_p1 <= bubble_cnt_p1 + 32'd1;
    end
  end

  assign fetch_count  = fetch_cnt_p1;
  assign bubble_count = bubble_cnt_p1;
`endif

  assign imem_addr   = pc_p0;
  assign if_id_pc    = if_id_pc_p1;
  assign if_id_instr = if_id_instr_p1;
  assign if_id_valid = vld_p1;
  assign halted      = (state_p0 == HALT);
  assign fault       = fault_p0;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus random
// stimulus, compared every cycle against a behavioural model of the fetch unit.
// The instruction memory returns the low 32 bits of the address as the word.
module tb_instruction_fetch;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        halt_req;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        halted;
  logic        fault;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [63:0] m_pc;
  logic        m_halt;
  logic        m_fault;
  logic [63:0] m_ipc;
  logic [31:0] m_instr;
  logic        m_valid;
  logic [31:0] m_fc;
  logic [31:0] m_bc;

  instruction_fetch #(.RESET_PC(64'h0), .NOP_INSTR(NOP)) dut (
    .clk(clk),
    .rst(rst),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .stall(stall),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .halt_req(halt_req),
    .if_id_pc(if_id_pc),
    .if_id_instr(if_id_instr),
    .if_id_valid(if_id_valid),
    .halted(halted),
    .fault(fault)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_count(fetch_count),
    .bubble_count(bubble_count)
`endif
  );

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr[31:0];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, clock, then compare all outputs.
  task automatic cycle(input logic r, input logic s, input logic b,
                       input logic [63:0] t, input logic h);
    rst = r; stall = s; branch_taken = b; branch_target = t; halt_req = h;
    if (r) begin
      m_pc = 64'h0; m_halt = 1'b0; m_fault = 1'b0;
      m_ipc = 64'h0; m_instr = NOP; m_valid = 1'b0;
      m_fc = 32'h0; m_bc = 32'h0;
    end else if (m_halt) begin
      // frozen
    end else if (b) begin
      m_ipc = m_pc; m_instr = NOP; m_valid = 1'b0; m_bc = m_bc + 1;
      if (t % 4 != 0) begin
        m_fault = 1'b1; m_halt = 1'b1;
      end else begin
        m_pc = t;
      end
    end else if (h) begin
      m_ipc = m_pc; m_instr = NOP; m_valid = 1'b0; m_bc = m_bc + 1;
      m_halt = 1'b1;
    end else if (!s) begin
      m_ipc = m_pc; m_instr = m_pc[31:0]; m_valid = 1'b1; m_fc = m_fc + 1;
      m_pc = m_pc + 64'd4;
    end
    @(posedge clk);
    #1;
    check("imem_addr", imem_addr, m_pc);
    check("if_id_pc", if_id_pc, m_ipc);
    check("if_id_instr", {32'h0, if_id_instr}, {32'h0, m_instr});
    check("if_id_valid", {63'h0, if_id_valid}, {63'h0, m_valid});
    check("halted", {63'h0, halted}, {63'h0, m_halt});
    check("fault", {63'h0, fault}, {63'h0, m_fault});
`ifdef IF_PERF_CNT_EN
    check("fetch_count", {32'h0, fetch_count}, {32'h0, m_fc});
    check("bubble_count", {32'h0, bubble_count}, {32'h0, m_bc});
`endif
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 64'h40, 1'b1);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 64'h0; halt_req = 1'b0;
    #2;

    // Reset state
    do_reset();
    check("rst_addr", imem_addr, 64'h0);
    check("rst_instr", {32'h0, if_id_instr}, {32'h0, NOP});
    check("rst_valid", {63'h0, if_id_valid}, 64'h0);
    check("rst_halted", {63'h0, halted}, 64'h0);

    // Straight-line fetch: 0,4,8,12
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
      check("seq_pc", if_id_pc, 64'(4 * i));
      check("seq_valid", {63'h0, if_id_valid}, 64'h1);
    end

    // Stall at PC=8
    do_reset();
    run(2);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
      check("stall_addr", imem_addr, 64'h8);
      check("stall_ipc", if_id_pc, 64'h4);
    end
    cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    check("release_ipc", if_id_pc, 64'h8);

    // Branch at PC=12 beats a simultaneous stall
    cycle(1'b0, 1'b1, 1'b1, 64'h100, 1'b0);
    check("br_addr", imem_addr, 64'h100);
    check("br_valid", {63'h0, if_id_valid}, 64'h0);
    check("br_instr", {32'h0, if_id_instr}, {32'h0, NOP});
    cycle(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    check("br_ipc", if_id_pc, 64'h100);

    // Misaligned redirect faults and halts, HALT ignores inputs, reset recovers
    cycle(1'b0, 1'b0, 1'b1, 64'h102, 1'b0);
    check("mis_fault", {63'h0, fault}, 64'h1);
    check("mis_halted", {63'h0, halted}, 64'h1);
    check("mis_addr", imem_addr, 64'h104);
    cycle(1'b0, 1'b1, 1'b1, 64'h200, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 64'h300, 1'b1);
    run(2);
    check("halt_addr", imem_addr, 64'h104);
    cycle(1'b1, 1'b0, 1'b1, 64'h500, 1'b0);
    check("rec_addr", imem_addr, 64'h0);
    check("rec_fault", {63'h0, fault}, 64'h0);
    check("rec_halted", {63'h0, halted}, 64'h0);

    // halt_req beats stall
    run(1);
    cycle(1'b0, 1'b1, 1'b0, 64'h0, 1'b1);
    check("hreq_halted", {63'h0, halted}, 64'h1);
    check("hreq_fault", {63'h0, fault}, 64'h0);
    do_reset();

    // PC wrap modulo 2^64
    cycle(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
    run(1);
    check("wrap_a", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    run(1);
    check("wrap_b", imem_addr, 64'h0);
    check("wrap_ipc", if_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);

`ifdef IF_PERF_CNT_EN
    // 5 fetches, 1 branch bubble, 2 stalls
    do_reset();
    run(3);
    cycle(1'b0, 1'b0, 1'b1, 64'h80, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
    run(2);
    check("perf_fetch", {32'h0, fetch_count}, 64'd5);
    check("perf_bubble", {32'h0, bubble_count}, 64'd1);
`endif

    // Random stimulus against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic        r, s, b, h;
      logic [63:0] t;
      r = ($urandom_range(0, 99) < 3);
      s = ($urandom_range(0, 99) < 30);
      b = ($urandom_range(0, 99) < 12);
      h = ($urandom_range(0, 99) < 3);
      t = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) t = {32'hFFFF_FFFF, 28'hFFF_FFFF, 4'($urandom_range(0, 15))};
      if ($urandom_range(0, 9) != 0) t[1:0] = 2'b00;
      cycle(r, s, b, t, h);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
